// File: rtl/ann_ctrl_pkg.sv
// Shared types and sizing for the ANN layer controllers.
package ann_ctrl_pkg;

  localparam int unsigned WEIGHT_DEPTH = 28;
  localparam int unsigned WEIGHT_AW    = 5;
  localparam int unsigned WEIGHT_DW    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/weight_bram_seq_ctrl.sv
// Sequences one weight BRAM: streamed load pass and in-order read pass to the MAC.
module weight_bram_seq_ctrl
  import ann_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WEIGHT_DEPTH,
  parameter int unsigned AW    = WEIGHT_AW,
  parameter int unsigned DW    = WEIGHT_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          rd_start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  output logic [AW-1:0] w_idx,
  output logic          w_last
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          w_valid_q, w_valid_d;
  logic [AW-1:0] w_idx_q, w_idx_d;
  logic          w_last_q, w_last_d;

  // State, counter and registered MAC-side outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      w_valid_q <= 1'b0;
      w_idx_q   <= '0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      w_valid_q <= w_valid_d;
      w_idx_q   <= w_idx_d;
      w_last_q  <= w_last_d;
    end
  end

  // Next state and BRAM port drive
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_ready = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;

    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end else if (rd_start) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        mem_en   = ld_valid;
        mem_we   = ld_valid;
        mem_addr = cnt_q;
        mem_di   = ld_data;
        if (ld_valid) begin
          if (cnt_q == LAST_ADDR) state_d = DONE;
          else                    cnt_d   = cnt_q + AW'(1);
        end
      end
      READ: begin
        mem_en   = 1'b1;
        mem_addr = cnt_q;
        if (cnt_q == LAST_ADDR) state_d = DRAIN;
        else                    cnt_d   = cnt_q + AW'(1);
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A read address issued now is delivered next cycle
    w_valid_d = (state_q == READ);
    w_idx_d   = (state_q == READ) ? cnt_q : '0;
    w_last_d  = (state_q == READ) && (cnt_q == LAST_ADDR);
    done_d    = (state_d == DONE);
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign w_valid = w_valid_q;
  assign w_idx   = w_idx_q;
  assign w_last  = w_last_q;
  assign w_data  = mem_do;

endmodule

// File: tb/tb_weight_bram_seq_ctrl.sv
// Directed bench for weight_bram_seq_ctrl with a behavioural falling-edge BRAM.
module tb_weight_bram_seq_ctrl;

  localparam int DEPTH = 28;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ld_start, ld_valid, rd_start;
  logic [15:0] ld_data;
  logic        ld_ready, busy, done;
  logic [4:0]  mem_addr;
  logic        mem_en, mem_we;
  logic [15:0] mem_di, mem_do, w_data;
  logic        w_valid, w_last;
  logic [4:0]  w_idx;

  logic [15:0] bram [DEPTH];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 CLK = ~CLK;

  weight_bram_seq_ctrl dut (
    .CLK(CLK), .RST(RST),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .rd_start(rd_start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_di(mem_di), .mem_do(mem_do),
    .w_data(w_data), .w_valid(w_valid), .w_idx(w_idx), .w_last(w_last)
  );

  // BRAM model: both write and read act on the falling edge
  always @(negedge CLK) begin
    if (mem_en && (int'(mem_addr) < DEPTH)) begin
      if (mem_we) begin
        bram[mem_addr] <= mem_di;
        wr_count       <= wr_count + 1;
      end else begin
        mem_do <= bram[mem_addr];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        ld_start;
    logic        rd_start;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        e_busy;
    logic        e_ready;
    logic        e_en;
    logic        e_we;
    logic        e_done;
    logic        e_wvalid;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 after the rising edge and sampled 1 later, before the falling edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    #1;
  endtask

  task automatic run_read(input int rst_at, input bit start_noise);
    rd_start = 1'b1;
    sample();
    chk("rd_issue_busy", 32'(busy), 32'd0);
    tick();
    rd_start = 1'b0;
    for (int t = 1; t <= 31; t++) begin
      if (start_noise && (t == 10 || t == 30)) rd_start = 1'b1;
      if (start_noise && t == 15) ld_start = 1'b1;
      RST = (rst_at > 0 && t == rst_at);
      sample();
      if (rst_at > 0 && t == rst_at + 1) begin
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        break;
      end
      chk("rd_w_valid", 32'(w_valid), 32'((t >= 2) && (t <= 29)));
      chk("rd_w_last", 32'(w_last), 32'(t == 29));
      chk("rd_done", 32'(done), 32'(t == 30));
      chk("rd_busy", 32'(busy), 32'(t <= 30));
      chk("rd_mem_en", 32'(mem_en), 32'(t <= 28));
      chk("rd_mem_we", 32'(mem_we), 32'd0);
      if (t <= 28) chk("rd_mem_addr", 32'(mem_addr), 32'(t - 1));
      if (t >= 2 && t <= 29) begin
        chk("rd_w_idx", 32'(w_idx), 32'(t - 2));
        chk("rd_w_data", 32'(w_data), 32'h0100 + 32'(t - 2));
      end
      tick();
      rd_start = 1'b0;
      ld_start = 1'b0;
      RST      = 1'b0;
    end
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int i;
    for (int k = 0; k < DEPTH; k++) bram[k] = 16'h0000;
    mem_do = 16'h0000;

    //                rst  lds  rds  ldv  data      busy rdy  en   we   done wv
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    RST = 1'b1; ld_start = 1'b0; rd_start = 1'b0; ld_valid = 1'b0; ld_data = 16'h0000;
    tick();
    tick();
    RST = 1'b0;
    sample();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_w_valid", 32'(w_valid), 32'd0);
    chk("reset_w_last", 32'(w_last), 32'd0);
    chk("reset_w_idx", 32'(w_idx), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_di", 32'(mem_di), 32'd0);
    tick();

    // Idle noise, reset in IDLE, then simultaneous starts
    for (int v = 0; v < 4; v++) begin
      RST = vecs[v].rst; ld_start = vecs[v].ld_start; rd_start = vecs[v].rd_start;
      ld_valid = vecs[v].ld_valid; ld_data = vecs[v].ld_data;
      sample();
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].e_busy));
      chk($sformatf("vec%0d_ready", v), 32'(ld_ready), 32'(vecs[v].e_ready));
      chk($sformatf("vec%0d_en", v), 32'(mem_en), 32'(vecs[v].e_en));
      chk($sformatf("vec%0d_we", v), 32'(mem_we), 32'(vecs[v].e_we));
      chk($sformatf("vec%0d_done", v), 32'(done), 32'(vecs[v].e_done));
      chk($sformatf("vec%0d_wvalid", v), 32'(w_valid), 32'(vecs[v].e_wvalid));
      tick();
    end
    RST = 1'b0; ld_start = 1'b0; rd_start = 1'b0;

    // Load pass with a gap on every third cycle
    c = 0;
    i = 0;
    while (i < DEPTH && c < 100) begin
      ld_valid = (c % 3 != 2);
      ld_data  = ld_valid ? 16'h0100 + 16'(i) : 16'hDEAD;
      sample();
      chk("ld_ready", 32'(ld_ready), 32'd1);
      chk("ld_busy", 32'(busy), 32'd1);
      chk("ld_mem_en", 32'(mem_en), 32'(ld_valid));
      chk("ld_mem_we", 32'(mem_we), 32'(ld_valid));
      chk("ld_done", 32'(done), 32'd0);
      if (ld_valid) begin
        chk("ld_mem_addr", 32'(mem_addr), 32'(i));
        chk("ld_mem_di", 32'(mem_di), 32'h0100 + 32'(i));
      end
      tick();
      if (ld_valid) i++;
      c++;
    end
    chk("ld_words_accepted", 32'(i), 32'(DEPTH));
    ld_valid = 1'b0;
    sample();
    chk("ld_done_pulse", 32'(done), 32'd1);
    chk("ld_done_ready", 32'(ld_ready), 32'd0);
    chk("ld_done_en", 32'(mem_en), 32'd0);
    tick();
    sample();
    chk("ld_after_done", 32'(done), 32'd0);
    chk("ld_after_busy", 32'(busy), 32'd0);
    chk("ld_after_ready", 32'(ld_ready), 32'd0);
    chk("ld_write_count", 32'(wr_count), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) chk($sformatf("bram_%0d", k), 32'(bram[k]), 32'h0100 + 32'(k));
    tick();

    run_read(0, 1'b0);

    // Starts while busy and in DONE are dropped
    run_read(0, 1'b1);
    sample();
    chk("noise_idle_busy", 32'(busy), 32'd0);
    tick();

    run_read(12, 1'b0);
    run_read(0, 1'b0);

    // Writes attempted from IDLE must not reach the BRAM
    for (int n = 0; n < 5; n++) begin
      ld_valid = 1'b1;
      ld_data  = 16'hFFFF;
      sample();
      chk("idle_noise_en", 32'(mem_en), 32'd0);
      chk("idle_noise_we", 32'(mem_we), 32'd0);
      tick();
    end
    ld_valid = 1'b0;
    run_read(0, 1'b0);
    chk("final_write_count", 32'(wr_count), 32'(DEPTH));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
